digits_to_time: RTL

//  Inverse of the stopwatch digit splitter: assembles four decimal digits entered one at a

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/bcd_pair_to_bin.sv | 18 +
 rtl/digits_to_time.sv | 123 ++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: entry FSM encoding, digit positions and time limits.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        S_MIN1,
        S_MIN0,
        S_SEC1,
        S_SEC0,
        S_LOAD
    } entry_state_e;

    localparam logic [1:0] IDX_MIN1 = 2'd0;
    localparam logic [1:0] IDX_MIN0 = 2'd1;
    localparam logic [1:0] IDX_SEC1 = 2'd2;
    localparam logic [1:0] IDX_SEC0 = 2'd3;

    localparam int unsigned MAX_MINUTES = 99;
    localparam int unsigned MAX_SECONDS = 59;
    localparam int unsigned MIN_W       = 7;
    localparam int unsigned SEC_W       = 6;

endpackage

// File: rtl/bcd_pair_to_bin.sv
// Combinational tens/ones decimal digit pair to binary, result width parameterised.
module bcd_pair_to_bin #(
    parameter int unsigned OutW = 7
) (
    input  logic [3:0]      tens_i,
    input  logic [3:0]      ones_i,
    output logic [OutW-1:0] bin_o
);

    logic [OutW-1:0] tens_w;

    // x10 as x8 + x2 keeps this a pair of adders, no multiplier.
    always_comb begin
        tens_w = OutW'(tens_i);
        bin_o  = (tens_w << 3) + (tens_w << 1) + OutW'(ones_i);
    end

endmodule

// File: rtl/digits_to_time.sv
// Assembles four strobed decimal digits (mm:ss, display order) into binary minutes/seconds
// with per-digit range checking and a one-cycle load pulse for the stopwatch preset port.
module digits_to_time
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_DIGIT    = 9,
    parameter int unsigned MAX_SEC_TENS = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       digit_in_i,
    input  logic             digit_valid_i,
    input  logic             cancel_i,
    output logic [MIN_W-1:0] minutes_o,
    output logic [SEC_W-1:0] seconds_o,
    output logic             load_o,
    output logic             err_o,
    output logic             busy_o,
    output logic [1:0]       digit_idx_o
);

    localparam logic [3:0] MaxDigitL   = 4'(MAX_DIGIT);
    localparam logic [3:0] MaxSecTensL = 4'(MAX_SEC_TENS);

    entry_state_e     state_q;
    logic [3:0]       min1_q, min0_q, sec1_q;
    logic [MIN_W-1:0] minutes_q;
    logic [SEC_W-1:0] seconds_q;
    logic             load_q, err_q, busy_q;
    logic [1:0]       idx_q;

    logic             legal;
    logic [MIN_W-1:0] min_bin;
    logic [SEC_W-1:0] sec_bin;

    always_comb begin
        legal = (state_q == S_SEC1) ? (digit_in_i <= MaxSecTensL) : (digit_in_i <= MaxDigitL);
    end

    bcd_pair_to_bin #(.OutW(MIN_W)) u_min_conv (
        .tens_i (min1_q),
        .ones_i (min0_q),
        .bin_o  (min_bin)
    );

    // sec0 converts straight from the input so the result lands on the edge that accepts it.
    bcd_pair_to_bin #(.OutW(SEC_W)) u_sec_conv (
        .tens_i (sec1_q),
        .ones_i (digit_in_i),
        .bin_o  (sec_bin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_MIN1;
            min1_q    <= '0;
            min0_q    <= '0;
            sec1_q    <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            load_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            idx_q     <= IDX_MIN1;
        end else begin
            load_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    state_q <= S_MIN1;
                    busy_q  <= 1'b0;
                    idx_q   <= IDX_MIN1;
                end
                default: begin
                    if (cancel_i) begin
                        state_q <= S_MIN1;
                        min1_q  <= '0;
                        min0_q  <= '0;
                        sec1_q  <= '0;
                        busy_q  <= 1'b0;
                        idx_q   <= IDX_MIN1;
                    end else if (digit_valid_i && !legal) begin
                        err_q <= 1'b1;
                    end else if (digit_valid_i) begin
                        busy_q <= 1'b1;
                        case (state_q)
                            S_MIN1: begin
                                min1_q  <= digit_in_i;
                                state_q <= S_MIN0;
                                idx_q   <= IDX_MIN0;
                            end
                            S_MIN0: begin
                                min0_q  <= digit_in_i;
                                state_q <= S_SEC1;
                                idx_q   <= IDX_SEC1;
                            end
                            S_SEC1: begin
                                sec1_q  <= digit_in_i;
                                state_q <= S_SEC0;
                                idx_q   <= IDX_SEC0;
                            end
                            default: begin
                                minutes_q <= min_bin;
                                seconds_q <= sec_bin;
                                load_q    <= 1'b1;
                                state_q   <= S_LOAD;
                                idx_q     <= IDX_SEC0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign minutes_o   = minutes_q;
    assign seconds_o   = seconds_q;
    assign load_o      = load_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;
    assign digit_idx_o = idx_q;

endmodule
